carfield_l2_dual_router: RTL and testbench

//  Routes one req/gnt memory port onto the two L2 ports, port 0 and port 1, of the dual-port L2.

---
 rtl/carfield_configuration.sv | 12 +
 rtl/carfield_l2_router_pkg.sv | 33 +++
 rtl/carfield_l2_router_ctr.sv | 39 +++
 rtl/carfield_l2_dual_router.sv | 233 +++++++++++++++++++++++
 tb/tb_carfield_l2_dual_router.sv | 361 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/carfield_configuration.sv
// carfield_configuration (minimal view)
//   The L2 address windows of the Carfield memory map. Only the constants
//   used by the dual-port L2 router are kept here.
//   Port 1 sits directly above port 0 and has the same power-of-2 size.
package carfield_configuration;

  localparam logic [63:0] L2Port0Base = 64'h0000_0000_7800_0000;
  localparam logic [63:0] L2Port0Size = 64'h0000_0000_0020_0000;
  localparam logic [63:0] L2Port1Base = L2Port0Base + L2Port0Size;
  localparam logic [63:0] L2Port1Size = L2Port0Size;

endpackage

// File: rtl/carfield_l2_router_pkg.sv
// carfield_l2_router_pkg
//   Shared types and the address decoder for the dual-port L2 router.
//   sel_e       : decoded target (L2 port 0, L2 port 1, error responder)
//   state_e     : router FSM states
//   addr_decode : window match on a 64-bit byte address
package carfield_l2_router_pkg;

  typedef enum logic [1:0] {
    SEL_P0  = 2'd0,
    SEL_P1  = 2'd1,
    SEL_ERR = 2'd2
  } sel_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_P0  = 2'd1,
    BUSY_P1  = 2'd2,
    ERR_RESP = 2'd3
  } state_e;

  // The window test uses (addr - base) < size after checking addr >= base so
  // that a window touching the top of the address space cannot wrap.
  function automatic sel_e addr_decode(input logic [63:0] addr,
                                       input logic [63:0] p0_base,
                                       input logic [63:0] p0_size,
                                       input logic [63:0] p1_base,
                                       input logic [63:0] p1_size);
    if ((addr >= p0_base) && ((addr - p0_base) < p0_size)) return SEL_P0;
    if ((addr >= p1_base) && ((addr - p1_base) < p1_size)) return SEL_P1;
    return SEL_ERR;
  endfunction

endpackage

// File: rtl/carfield_l2_router_ctr.sv
// carfield_l2_router_ctr
//   Up/down counter of accepted-but-unanswered requests.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_inc          : one request accepted this cycle
//   i_dec          : one response returned this cycle
//   o_cnt          : current count, 0..MaxCount
//   o_full         : count == MaxCount
//   o_empty        : count == 0
module carfield_l2_router_ctr #(
  parameter int unsigned MaxCount = 4,
  localparam int unsigned CntW = $clog2(MaxCount + 1)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_inc,
  input  logic            i_dec,
  output logic [CntW-1:0] o_cnt,
  output logic            o_full,
  output logic            o_empty
);

  logic [CntW-1:0] r_cnt;

  // Simultaneous inc and dec cancel out.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_inc && !i_dec) begin
      r_cnt <= r_cnt + CntW'(1);
    end else if (i_dec && !i_inc) begin
      r_cnt <= r_cnt - CntW'(1);
    end
  end

  assign o_cnt   = r_cnt;
  assign o_full  = (r_cnt == CntW'(MaxCount));
  assign o_empty = (r_cnt == '0);

endmodule

// File: rtl/carfield_l2_dual_router.sv
// carfield_l2_dual_router
//   Routes one req/gnt memory port onto the two ports of the dual-port L2.
//   Addresses in the port 0 / port 1 windows are forwarded (offset within the
//   window) with zero-latency grant; anything else is answered by an internal
//   error responder. All outstanding requests target one port at a time, so
//   responses return strictly in order.
//
//   Optional build macro CARFIELD_L2_ROUTER_STATS_EN adds saturating 32-bit
//   counters of granted requests per target (stat_p0_o, stat_p1_o, stat_err_o).
//
//   Ports
//     clk_i, rst_ni         clock, asynchronous active-low reset
//     mst_req_i/mst_gnt_o   master request / accept
//     mst_addr_i/we/be/wdata master request fields (held until grant)
//     mst_rvalid_o/rdata_o  response (combinationally forwarded)
//     mst_err_o             decode error on this response
//     l2_req_o[1:0]         per-port request
//     l2_gnt_i[1:0]         per-port grant
//     l2_addr_o/we/be/wdata shared request fields, address relative to window
//     l2_rvalid_i, l2_rdata_i per-port in-order responses
module carfield_l2_dual_router
  import carfield_l2_router_pkg::*;
#(
  parameter int unsigned AddrWidth      = 64,
  parameter int unsigned DataWidth      = 64,
  parameter int unsigned MaxOutstanding = 4,
  parameter logic [63:0] Port0Base      = carfield_configuration::L2Port0Base,
  parameter logic [63:0] Port0Size      = carfield_configuration::L2Port0Size,
  parameter logic [63:0] Port1Base      = carfield_configuration::L2Port1Base,
  parameter logic [63:0] Port1Size      = carfield_configuration::L2Port1Size,
  parameter logic [31:0] ErrData        = 32'hBADC_AB1E
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      mst_req_i,
  output logic                      mst_gnt_o,
  input  logic [AddrWidth-1:0]      mst_addr_i,
  input  logic                      mst_we_i,
  input  logic [DataWidth/8-1:0]    mst_be_i,
  input  logic [DataWidth-1:0]      mst_wdata_i,
  output logic                      mst_rvalid_o,
  output logic [DataWidth-1:0]      mst_rdata_o,
  output logic                      mst_err_o,
  output logic [1:0]                l2_req_o,
  input  logic [1:0]                l2_gnt_i,
  output logic [AddrWidth-1:0]      l2_addr_o,
  output logic                      l2_we_o,
  output logic [DataWidth/8-1:0]    l2_be_o,
  output logic [DataWidth-1:0]      l2_wdata_o,
  input  logic [1:0]                l2_rvalid_i,
  input  logic [1:0][DataWidth-1:0] l2_rdata_i
`ifdef CARFIELD_L2_ROUTER_STATS_EN
  ,
  output logic [31:0]               stat_p0_o,
  output logic [31:0]               stat_p1_o,
  output logic [31:0]               stat_err_o
`endif
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  state_e          r_state;
  state_e          w_state_nxt;
  sel_e            w_sel;
  logic [63:0]     w_addr64;
  logic            w_accept;
  logic            w_fwd;
  logic            w_gnt;
  logic            w_l2_grant;
  logic            w_cur_rvalid;
  logic [DataWidth-1:0] w_cur_rdata;
  logic            w_rsp;
  logic [CntW-1:0] w_cnt;
  logic            w_full;
  logic            w_empty;

  assign w_addr64 = 64'(mst_addr_i);
  assign w_sel    = addr_decode(w_addr64, Port0Base, Port0Size, Port1Base, Port1Size);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Handshake outputs are gated with rst_ni so the master and both L2 ports
  // see an idle router while reset is held, even if mst_req_i stays high.
  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_cur_rvalid = 1'b0;
    w_cur_rdata  = '0;
    l2_req_o     = '0;
    w_gnt        = 1'b0;
    mst_rdata_o  = '0;

    // A request is only admitted when it targets the port already in use;
    // switching targets waits for the router to drain back to IDLE, which
    // is what keeps responses in order without any reorder buffer.
    case (r_state)
      IDLE: begin
        w_accept = 1'b1;
      end
      BUSY_P0: begin
        w_accept     = (w_sel == SEL_P0) && !w_full;
        w_cur_rvalid = l2_rvalid_i[0] && !w_empty;
        w_cur_rdata  = l2_rdata_i[0];
      end
      BUSY_P1: begin
        w_accept     = (w_sel == SEL_P1) && !w_full;
        w_cur_rvalid = l2_rvalid_i[1] && !w_empty;
        w_cur_rdata  = l2_rdata_i[1];
      end
      default: begin
        w_accept = 1'b0;
      end
    endcase

    w_fwd = rst_ni && mst_req_i && w_accept;

    case (w_sel)
      SEL_P0: begin
        l2_req_o[0] = w_fwd;
        w_gnt       = w_fwd && l2_gnt_i[0];
      end
      SEL_P1: begin
        l2_req_o[1] = w_fwd;
        w_gnt       = w_fwd && l2_gnt_i[1];
      end
      default: begin
        // The error responder can always take the request at once.
        w_gnt = w_fwd;
      end
    endcase

    w_l2_grant   = w_gnt && (w_sel != SEL_ERR);
    w_rsp        = rst_ni && w_cur_rvalid;
    mst_err_o    = rst_ni && (r_state == ERR_RESP);
    mst_rvalid_o = w_rsp || mst_err_o;
    if (w_rsp) begin
      mst_rdata_o = w_cur_rdata;
    end else if (mst_err_o) begin
      mst_rdata_o = DataWidth'(ErrData);
    end

    case (r_state)
      IDLE: begin
        if (w_gnt) begin
          case (w_sel)
            SEL_P0:  w_state_nxt = BUSY_P0;
            SEL_P1:  w_state_nxt = BUSY_P1;
            default: w_state_nxt = ERR_RESP;
          endcase
        end
      end
      BUSY_P0, BUSY_P1: begin
        // Last response leaves with no new grant in the same cycle.
        if (w_rsp && !w_l2_grant && (w_cnt == CntW'(1))) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign mst_gnt_o = w_gnt;

  always_comb begin
    l2_addr_o = '0;
    case (w_sel)
      SEL_P0:  l2_addr_o = AddrWidth'(w_addr64 - Port0Base);
      SEL_P1:  l2_addr_o = AddrWidth'(w_addr64 - Port1Base);
      default: l2_addr_o = '0;
    endcase
  end

  assign l2_we_o    = mst_we_i;
  assign l2_be_o    = mst_be_i;
  assign l2_wdata_o = mst_wdata_i;

  carfield_l2_router_ctr #(
    .MaxCount(MaxOutstanding)
  ) u_ctr (
    .i_clk  (clk_i),
    .i_rst_n(rst_ni),
    .i_inc  (w_l2_grant),
    .i_dec  (w_rsp),
    .o_cnt  (w_cnt),
    .o_full (w_full),
    .o_empty(w_empty)
  );

`ifdef CARFIELD_L2_ROUTER_STATS_EN
  logic [31:0] r_stat_p0;
  logic [31:0] r_stat_p1;
  logic [31:0] r_stat_err;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stat_p0  <= '0;
      r_stat_p1  <= '0;
      r_stat_err <= '0;
    end else if (w_gnt) begin
      case (w_sel)
        SEL_P0:  r_stat_p0  <= sat_inc(r_stat_p0);
        SEL_P1:  r_stat_p1  <= sat_inc(r_stat_p1);
        default: r_stat_err <= sat_inc(r_stat_err);
      endcase
    end
  end

  assign stat_p0_o  = r_stat_p0;
  assign stat_p1_o  = r_stat_p1;
  assign stat_err_o = r_stat_err;
`endif

`ifndef SYNTHESIS
  // A response from a port with nothing outstanding on it is dropped.
  a_p0_stray_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    l2_rvalid_i[0] |-> ((r_state == BUSY_P0) && !w_empty));
  a_p1_stray_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    l2_rvalid_i[1] |-> ((r_state == BUSY_P1) && !w_empty));
`endif

endmodule

// File: tb/tb_carfield_l2_dual_router.sv
module tb_carfield_l2_dual_router;

  localparam int unsigned MAXO = 4;
  localparam logic [63:0] P0B  = 64'h7800_0000;
  localparam logic [63:0] P0S  = 64'h0020_0000;
  localparam logic [63:0] P1B  = 64'h7820_0000;
  localparam logic [63:0] P1S  = 64'h0020_0000;
  localparam logic [63:0] ERRD = 64'h0000_0000_BADC_AB1E;

  logic clk = 1'b0;
  logic rst_n;
  logic req, gnt, we, rvalid, err;
  logic [63:0] addr, wdata, rdata;
  logic [7:0] be;
  logic [1:0] l2_req, l2_gnt, l2_rvalid;
  logic [63:0] l2_addr, l2_wdata;
  logic l2_we;
  logic [7:0] l2_be;
  logic [1:0][63:0] l2_rdata;
`ifdef CARFIELD_L2_ROUTER_STATS_EN
  logic [31:0] stat_p0, stat_p1, stat_err;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model: targets of accepted L2 requests in issue order, plus a
  // flag for an error response due in the current cycle.
  int inflight[$];
  bit err_due = 1'b0;
  bit last_gnt = 1'b0;

  always #5 clk = ~clk;

  carfield_l2_dual_router dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .mst_req_i   (req),
    .mst_gnt_o   (gnt),
    .mst_addr_i  (addr),
    .mst_we_i    (we),
    .mst_be_i    (be),
    .mst_wdata_i (wdata),
    .mst_rvalid_o(rvalid),
    .mst_rdata_o (rdata),
    .mst_err_o   (err),
    .l2_req_o    (l2_req),
    .l2_gnt_i    (l2_gnt),
    .l2_addr_o   (l2_addr),
    .l2_we_o     (l2_we),
    .l2_be_o     (l2_be),
    .l2_wdata_o  (l2_wdata),
    .l2_rvalid_i (l2_rvalid),
    .l2_rdata_i  (l2_rdata)
`ifdef CARFIELD_L2_ROUTER_STATS_EN
    ,
    .stat_p0_o   (stat_p0),
    .stat_p1_o   (stat_p1),
    .stat_err_o  (stat_err)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  function automatic int tgt_of(input logic [63:0] a);
    if (a >= P0B && a < P0B + P0S) return 0;
    if (a >= P1B && a < P1B + P1S) return 1;
    return 2;
  endfunction

  task automatic drive(input bit r, input logic [63:0] a, input bit w,
                       input logic [1:0] g, input logic [1:0] rv);
    req         = r;
    addr        = a;
    we          = w;
    be          = 8'($urandom);
    wdata       = {$urandom, $urandom};
    l2_gnt      = g;
    l2_rvalid   = rv;
    l2_rdata[0] = {$urandom, $urandom};
    l2_rdata[1] = {$urandom, $urandom};
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  // Compare every output against the model, then advance one clock.
  task automatic step();
    int t;
    bit acc, want_gnt, want_rv;
    logic [1:0] want_req;
    logic [63:0] want_rd;
    t = tgt_of(addr);
    if (!rst_n) begin
      chk("rst_gnt", gnt, 0);
      chk("rst_l2_req", l2_req, 0);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_err", err, 0);
      chk("rst_rdata", rdata, 0);
      inflight.delete();
      err_due  = 1'b0;
      last_gnt = 1'b0;
      @(posedge clk);
      #1;
      return;
    end
    if (err_due) acc = 1'b0;
    else if (inflight.size() == 0) acc = 1'b1;
    else acc = (t != 2) && (inflight[0] == t) && (inflight.size() < MAXO);
    want_req = '0;
    if (req && acc && t != 2) want_req[t] = 1'b1;
    want_gnt = req && acc && ((t == 2) || l2_gnt[t]);
    want_rv  = err_due;
    want_rd  = ERRD;
    if (!err_due && inflight.size() > 0 && l2_rvalid[inflight[0]]) begin
      want_rv = 1'b1;
      want_rd = l2_rdata[inflight[0]];
    end
    chk("gnt", gnt, want_gnt);
    chk("l2_req", l2_req, want_req);
    chk("rvalid", rvalid, want_rv);
    chk("err", err, err_due);
    if (want_rv) chk("rdata", rdata, want_rd);
    if (want_req != 0) begin
      chk("l2_addr", l2_addr, addr - ((t == 0) ? P0B : P1B));
      chk("l2_we", l2_we, we);
      chk("l2_be", l2_be, be);
      chk("l2_wdata", l2_wdata, wdata);
    end
    last_gnt = want_gnt;
    @(posedge clk);
    if (want_rv && !err_due) void'(inflight.pop_front());
    if (want_gnt && t != 2) inflight.push_back(t);
    err_due = want_gnt && (t == 2);
    #1;
  endtask

  task automatic cycle();
    settle();
    step();
  endtask

  initial begin
    bit pending;
    int r;
    logic [63:0] ra;

    // Reset with an active request and both grants high: everything stays 0.
    rst_n = 1'b0;
    drive(1, P0B + 64'h40, 0, 2'b11, 2'b00);
    #1;
    settle();
    chk("reset_gnt", gnt, 0);
    chk("reset_l2_req", l2_req, 0);
    step();
    cycle();
    rst_n = 1'b1;

    // Single P0 read: immediate grant, offset address, response 2 cycles later.
    drive(1, 64'h7800_0040, 0, 2'b01, 2'b00);
    settle();
    chk("t1_gnt", gnt, 1);
    chk("t1_l2_req", l2_req, 2'b01);
    chk("t1_l2_addr", l2_addr, 64'h40);
    step();
    drive(0, 64'h7800_0040, 0, 2'b00, 2'b00);
    cycle();
    drive(0, 64'h7800_0040, 0, 2'b00, 2'b01);
    l2_rdata[0] = 64'h1122_3344_5566_7788;
    settle();
    chk("t1_rvalid", rvalid, 1);
    chk("t1_rdata", rdata, 64'h1122_3344_5566_7788);
    chk("t1_err", err, 0);
    step();

    // Four P1 reads fill the outstanding budget; the fifth waits for a response.
    for (int i = 0; i < 4; i++) begin
      drive(1, P1B + 64'(i * 8), 0, 2'b10, 2'b00);
      cycle();
    end
    drive(1, P1B + 64'h20, 0, 2'b10, 2'b00);
    settle();
    chk("t2_full_gnt", gnt, 0);
    chk("t2_full_req", l2_req, 2'b00);
    step();
    cycle();
    l2_rvalid = 2'b10;
    settle();
    chk("t2_rsp_rvalid", rvalid, 1);
    chk("t2_rsp_gnt", gnt, 0);
    step();
    l2_rvalid = 2'b00;
    settle();
    chk("t2_fifth_gnt", gnt, 1);
    step();
    for (int i = 0; i < 4; i++) begin
      drive(0, P1B, 0, 2'b00, 2'b10);
      cycle();
    end

    // P0 outstanding holds off a P1 request until the P0 response is back.
    drive(1, P0B + 64'h100, 0, 2'b01, 2'b00);
    cycle();
    drive(1, P1B + 64'h100, 0, 2'b11, 2'b00);
    settle();
    chk("t3_held_req", l2_req, 2'b00);
    chk("t3_held_gnt", gnt, 0);
    step();
    cycle();
    l2_rvalid = 2'b01;
    settle();
    chk("t3_rsp_gnt", gnt, 0);
    step();
    l2_rvalid = 2'b00;
    settle();
    chk("t3_switch_gnt", gnt, 1);
    chk("t3_switch_req", l2_req, 2'b10);
    step();
    drive(0, P1B, 0, 2'b00, 2'b10);
    cycle();

    // Unmapped read and write answered by the error responder.
    drive(1, 64'h1000_0000, 0, 2'b00, 2'b00);
    settle();
    chk("t4_err_gnt", gnt, 1);
    chk("t4_err_l2_req", l2_req, 2'b00);
    step();
    drive(0, 64'h1000_0000, 0, 2'b00, 2'b00);
    settle();
    chk("t4_err_rvalid", rvalid, 1);
    chk("t4_err_flag", err, 1);
    chk("t4_err_rdata", rdata, ERRD);
    step();
    drive(1, P1B + P1S, 1, 2'b11, 2'b00);
    cycle();
    drive(0, P1B + P1S, 0, 2'b00, 2'b00);
    cycle();

    // Window edges; an error request waits while P0 is busy.
    drive(1, P0B + P0S - 8, 0, 2'b01, 2'b00);
    settle();
    chk("edge_p0_last_req", l2_req, 2'b01);
    chk("edge_p0_last_addr", l2_addr, P0S - 8);
    step();
    drive(1, P0B - 8, 0, 2'b11, 2'b00);
    settle();
    chk("edge_err_busy_gnt", gnt, 0);
    step();
    l2_rvalid = 2'b01;
    cycle();
    l2_rvalid = 2'b00;
    cycle();
    drive(1, P1B + P1S - 8, 0, 2'b10, 2'b00);
    settle();
    chk("edge_during_err_gnt", gnt, 0);
    step();
    settle();
    chk("edge_p1_last_addr", l2_addr, P1S - 8);
    step();
    drive(0, P1B, 0, 2'b00, 2'b10);
    cycle();

    // Grant and response together at count 2 leave the count at 2.
    drive(1, P0B, 0, 2'b01, 2'b00);
    cycle();
    drive(1, P0B + 8, 0, 2'b01, 2'b00);
    cycle();
    drive(1, P0B + 16, 0, 2'b01, 2'b01);
    cycle();
    drive(1, P0B + 24, 0, 2'b01, 2'b00);
    cycle();
    drive(1, P0B + 32, 0, 2'b01, 2'b00);
    cycle();
    drive(1, P0B + 40, 0, 2'b01, 2'b00);
    settle();
    chk("t5_cnt_full_gnt", gnt, 0);
    step();

    // Reset mid-burst clears everything; a P1 request is then taken at once.
    rst_n = 1'b0;
    drive(1, P0B + 40, 0, 2'b11, 2'b00);
    settle();
    chk("t5_rst_gnt", gnt, 0);
    chk("t5_rst_l2_req", l2_req, 2'b00);
    chk("t5_rst_rvalid", rvalid, 0);
    chk("t5_rst_err", err, 0);
    chk("t5_rst_rdata", rdata, 0);
    step();
    rst_n = 1'b1;
    drive(1, P1B + 64'h40, 0, 2'b10, 2'b00);
    settle();
    chk("t5_after_rst_gnt", gnt, 1);
    step();
    drive(0, P1B, 0, 2'b00, 2'b10);
    cycle();

    // Per-target grant counts from a fresh reset.
    rst_n = 1'b0;
    drive(0, P0B, 0, 2'b00, 2'b00);
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1, P0B + 64'(i * 8), 0, 2'b01, 2'b00);
      cycle();
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, P0B, 0, 2'b00, 2'b01);
      cycle();
    end
    for (int i = 0; i < 2; i++) begin
      drive(1, P1B + 64'(i * 8), 0, 2'b10, 2'b00);
      cycle();
    end
    for (int i = 0; i < 2; i++) begin
      drive(0, P1B, 0, 2'b00, 2'b10);
      cycle();
    end
    drive(1, 64'h2000_0000, 1, 2'b00, 2'b00);
    cycle();
    drive(0, 64'h2000_0000, 0, 2'b00, 2'b00);
    cycle();
`ifdef CARFIELD_L2_ROUTER_STATS_EN
    chk("stat_p0", stat_p0, 3);
    chk("stat_p1", stat_p1, 2);
    chk("stat_err", stat_err, 1);
`endif

    // Random traffic; the master holds each request until it is granted.
    pending = 1'b0;
    for (int c = 0; c < 800; c++) begin
      if (!pending && $urandom_range(0, 3) != 0) begin
        pending = 1'b1;
        r = int'($urandom_range(0, 9));
        if (r < 5)      ra = P0B + 64'($urandom_range(0, 32'h3FFFF)) * 8;
        else if (r < 9) ra = P1B + 64'($urandom_range(0, 32'h3FFFF)) * 8;
        else            ra = 64'h1000_0000 + 64'($urandom_range(0, 32'hFFFF)) * 8;
        drive(1, ra, 1'($urandom), 2'b00, 2'b00);
      end
      req       = pending;
      l2_gnt    = 2'($urandom);
      l2_rvalid = 2'b00;
      if (inflight.size() > 0 && !err_due && $urandom_range(0, 2) == 0)
        l2_rvalid[inflight[0]] = 1'b1;
      l2_rdata[0] = {$urandom, $urandom};
      l2_rdata[1] = {$urandom, $urandom};
      cycle();
      if (last_gnt) pending = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
